ram_bank: RTL and testbench
===========================

RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 9, address width; depth SHALL be 2**ADDR_W words (512 at default).
REQ-003 Parameter CLR_ON_RST, default 1; 1 = automatic clear sweep after reset release.
REQ-004 Derived constant BE_W = DATA_W/8, the byte-lane count.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 cs  in  1  chip select; qualifies every access.
REQ-008 write  in  1  1 = write access, 0 = read access (qualified by cs).
REQ-009 be  in  BE_W  byte-lane write enables; bit i covers din[8i+7:8i].
REQ-010 addr  in  ADDR_W  word address.
REQ-011 din  in  DATA_W  write data.
REQ-012 dout  out  DATA_W  registered read data; never tri-stated.
REQ-013 rvalid  out  1  one-cycle pulse; dout holds a fresh read result.
REQ-014 clr_req  in  1  one-cycle request to zero the whole array.
REQ-015 busy  out  1  1 while a clear sweep runs; accesses are ignored.

Function
REQ-016 The FSM SHALL have two states, IDLE and CLEAR; busy = (state == CLEAR).
REQ-017 In CLEAR, one word per cycle SHALL be written to 0 at the sweep counter, counter 0 up to DEPTH-1, then IDLE on the next edge; sweep = exactly DEPTH cycles.
REQ-018 In IDLE, clr_req = 1 SHALL enter CLEAR with counter 0 on the next edge; clr_req in CLEAR SHALL be ignored (no restart).
REQ-019 Read: cs=1, write=0 in IDLE at edge N -> dout = mem[addr] and rvalid = 1 after edge N+1; latency 1 cycle.
REQ-020 rvalid SHALL be 0 in every cycle not directly following an accepted read; dout SHALL hold its last value otherwise.
REQ-021 Write: cs=1, write=1 in IDLE SHALL update only lanes with be[i]=1; other lanes unchanged; be=0 = no change; rvalid stays 0.
REQ-022 A read of an address on the cycle after a write to it SHALL return the new data.
REQ-023 cs=0 SHALL leave memory, dout and rvalid-low behaviour unaffected regardless of write/be/addr.
REQ-024 Any access presented while busy=1 SHALL be dropped: no memory change, no rvalid.
REQ-025 clr_req and an access in the same IDLE cycle: the access SHALL complete (write applied / read returned), and the clear starts that same edge.
REQ-026 The sweep counter SHALL be ADDR_W bits; no out-of-range address exists.

Reset
REQ-027 rst=1 SHALL force asynchronously: dout = 0, rvalid = 0, counter = 0, state = CLEAR if CLR_ON_RST=1 else IDLE.
REQ-028 Memory array contents SHALL NOT be reset directly; zeroing occurs only through the sweep.
REQ-029 rst asserted mid-sweep SHALL abort it; after release the sweep restarts from address 0 (CLR_ON_RST=1).

Structure
REQ-030 Package ram_pkg SHALL hold the state enum (IDLE, CLEAR) and the default DATA_W/ADDR_W constants.
REQ-031 Single module, no sub-modules; array inferable as block RAM (synchronous write and read, byte-enable write).
REQ-032 An elaboration check SHALL reject DATA_W not a multiple of 8.

Verification
REQ-033 Reset release, CLR_ON_RST=1, defaults: busy=1 for exactly 512 cycles, then 0; a read of addr 0x1FF returns 0x0000.
REQ-034 Write 0xBEEF to 0x005 with be=11; read 0x005 next cycle: dout=0xBEEF, rvalid=1 for one cycle only.
REQ-035 Write 0x1234 with be=01 over 0xBEEF at 0x005: read returns 0xBE34.
REQ-036 Write 0xAAAA to 0x010; pulse clr_req; write 0x5555 to 0x010 while busy; after busy falls, read 0x010 returns 0x0000.
REQ-037 Assert rst at sweep counter 100; release: busy=1 for a full 512 cycles again; dout=0, rvalid=0 during reset.
REQ-038 cs=0, write=1, be=11, din=0xFFFF at 0x020 after 0x020 holds 0x0001: later read returns 0x0001.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and default sizes for the clearable RAM bank.
// State encoding and word/address width defaults live here.
package ram_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 9;

endpackage

// File: rtl/ram_bank.sv
// Single-port byte-enable RAM with a registered read port and a
// hardware clear sweep that zeroes one word per cycle.
module ram_bank
    import ram_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int CLR_ON_RST = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  write,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     din,
    output logic [DATA_W-1:0]     dout,
    output logic                  rvalid,
    input  logic                  clr_req,
    output logic                  busy
);

    localparam int BE_W  = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam state_t RST_STATE = (CLR_ON_RST != 0) ? CLEAR : IDLE;

    if (DATA_W % 8 != 0) begin : g_bad_width
        $error("ram_bank: DATA_W must be a multiple of 8");
    end

    logic [DATA_W-1:0] mem [DEPTH];

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   cnt;
    logic                acc_ok;
    logic                wr_en;
    logic                rd_en;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [BE_W-1:0]     wlane;

    assign busy   = (state == CLEAR);
    assign acc_ok = cs && (state == IDLE);
    assign wr_en  = acc_ok && write;
    assign rd_en  = acc_ok && !write;

    // State register; reset lands in CLEAR when an auto-sweep is wanted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RST_STATE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: clear requests only count in IDLE; sweep ends on last word.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:  if (clr_req) next_state = CLEAR;
            CLEAR: if (cnt == {ADDR_W{1'b1}}) next_state = IDLE;
            default: next_state = state;
        endcase
    end

    // Sweep counter runs only in CLEAR and sits at 0 otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Write port mux: the sweep owns the port while busy.
    always_comb begin
        waddr = addr;
        wdata = din;
        wlane = '0;
        if (busy) begin
            waddr = cnt;
            wdata = '0;
            wlane = '1;
        end else if (wr_en) begin
            wlane = be;
        end
    end

    // Array write with per-lane enables; kept reset-free for RAM inference.
    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wlane[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // Registered read port; dout holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout   <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_en;
            if (rd_en) begin
                dout <= mem[addr];
            end
        end
    end

endmodule

// File: tb/tb_ram_bank.sv
// Self-checking bench for ram_bank: directed vector table, reset and
// clear sequences, then random traffic against an array-based model.
module tb_ram_bank;

    localparam int DW    = 16;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cs = 1'b0;
    logic          write = 1'b0;
    logic [1:0]    be = '0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] dout;
    logic          rvalid;
    logic          clr_req = 1'b0;
    logic          busy;

    ram_bank #(.DATA_W(DW), .ADDR_W(AW), .CLR_ON_RST(1)) dut (
        .clk(clk), .rst(rst), .cs(cs), .write(write), .be(be),
        .addr(addr), .din(din), .dout(dout), .rvalid(rvalid),
        .clr_req(clr_req), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mm [DEPTH];
    int            m_busy = 0;
    logic          m_rv = 1'b0;
    logic [DW-1:0] m_dout = '0;

    typedef struct {
        logic          cs;
        logic          wr;
        logic [1:0]    be;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        logic          rv;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic c, input logic w, input logic clr,
                          input logic [1:0] b, input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
        cs = c; write = w; clr_req = clr; be = b; addr = a; din = d;
    endtask

    task automatic idle_in();
        set_in(1'b0, 1'b0, 1'b0, 2'b00, '0, '0);
    endtask

    task automatic zero_model();
        for (int j = 0; j < DEPTH; j++) mm[j] = '0;
    endtask

    // One clock: update the model from the applied inputs, then compare.
    task automatic step();
        @(posedge clk);
        m_rv = 1'b0;
        if (m_busy > 0) begin
            m_busy--;
        end else begin
            if (cs && write) begin
                for (int i = 0; i < 2; i++)
                    if (be[i]) mm[addr][8*i +: 8] = din[8*i +: 8];
            end else if (cs) begin
                m_rv = 1'b1;
                m_dout = mm[addr];
            end
            if (clr_req) begin
                zero_model();
                m_busy = DEPTH;
            end
        end
        #1;
        chk("busy", 32'(busy), 32'(m_busy > 0));
        chk("rvalid", 32'(rvalid), 32'(m_rv));
        chk("dout", 32'(dout), 32'(m_dout));
    endtask

    task automatic apply_reset(input int hold);
        idle_in();
        rst = 1'b1;
        #1;
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        repeat (hold) @(posedge clk);
        #1;
        chk("rst_hold_dout", 32'(dout), 32'h0);
        chk("rst_hold_rvalid", 32'(rvalid), 32'h0);
        rst = 1'b0;
        zero_model();
        m_busy = DEPTH;
        m_rv = 1'b0;
        m_dout = '0;
    endtask

    task automatic count_sweep(input string name);
        int n;
        n = 0;
        idle_in();
        while (busy && n < 600) begin
            step();
            n++;
        end
        chk(name, 32'(n), 32'd512);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2'b00, 9'h1FF, 16'h0000, 1'b1, 16'h0000};
        tbl[1]  = '{1'b1, 1'b1, 2'b11, 9'h005, 16'hBEEF, 1'b0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 2'b00, 9'h005, 16'h0000, 1'b1, 16'hBEEF};
        tbl[3]  = '{1'b0, 1'b0, 2'b00, 9'h005, 16'h0000, 1'b0, 16'hBEEF};
        tbl[4]  = '{1'b1, 1'b1, 2'b01, 9'h005, 16'h1234, 1'b0, 16'hBEEF};
        tbl[5]  = '{1'b1, 1'b0, 2'b00, 9'h005, 16'h0000, 1'b1, 16'hBE34};
        tbl[6]  = '{1'b1, 1'b1, 2'b11, 9'h020, 16'h0001, 1'b0, 16'hBE34};
        tbl[7]  = '{1'b0, 1'b1, 2'b11, 9'h020, 16'hFFFF, 1'b0, 16'hBE34};
        tbl[8]  = '{1'b1, 1'b0, 2'b00, 9'h020, 16'h0000, 1'b1, 16'h0001};
        tbl[9]  = '{1'b1, 1'b1, 2'b10, 9'h021, 16'h5678, 1'b0, 16'h0001};
        tbl[10] = '{1'b1, 1'b0, 2'b00, 9'h021, 16'h0000, 1'b1, 16'h5600};
        tbl[11] = '{1'b1, 1'b1, 2'b00, 9'h005, 16'hFFFF, 1'b0, 16'h5600};
        tbl[12] = '{1'b1, 1'b0, 2'b00, 9'h005, 16'h0000, 1'b1, 16'hBE34};
        tbl[13] = '{1'b0, 1'b0, 2'b00, 9'h005, 16'h0000, 1'b0, 16'hBE34};

        #2;
        apply_reset(3);
        chk("busy_after_release", 32'(busy), 32'h1);
        count_sweep("sweep_len_first");

        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].cs, tbl[i].wr, 1'b0, tbl[i].be,
                   tbl[i].addr, tbl[i].din);
            step();
            chk($sformatf("vec%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
            chk($sformatf("vec%0d_dout", i), 32'(dout), 32'(tbl[i].dout));
        end

        // Read together with clr_req: read completes, sweep starts.
        set_in(1'b1, 1'b0, 1'b1, 2'b00, 9'h005, '0);
        step();
        chk("clr_read_dout", 32'(dout), 32'hBE34);
        chk("clr_read_rvalid", 32'(rvalid), 32'h1);
        chk("clr_read_busy", 32'(busy), 32'h1);
        idle_in();
        repeat (100) step();
        chk("mid_sweep_busy", 32'(busy), 32'h1);

        // Abort the sweep with reset; full sweep must follow.
        apply_reset(3);
        count_sweep("sweep_len_after_abort");

        // Clear wipes old data; a write while busy is dropped.
        set_in(1'b1, 1'b1, 1'b0, 2'b11, 9'h010, 16'hAAAA);
        step();
        set_in(1'b1, 1'b0, 1'b1, 2'b00, 9'h010, '0);
        step();
        chk("pre_clr_read", 32'(dout), 32'hAAAA);
        set_in(1'b1, 1'b1, 1'b0, 2'b11, 9'h010, 16'h5555);
        step();
        chk("busy_write_no_rvalid", 32'(rvalid), 32'h0);
        begin
            int n;
            n = 1;
            idle_in();
            while (busy && n < 600) begin
                step();
                n++;
            end
            chk("clr_sweep_len", 32'(n), 32'd512);
        end
        set_in(1'b1, 1'b0, 1'b0, 2'b00, 9'h010, '0);
        step();
        chk("post_clr_read", 32'(dout), 32'h0000);
        chk("post_clr_rvalid", 32'(rvalid), 32'h1);

        // Random traffic over a small address window.
        for (int k = 0; k < 600; k++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(0, 15) == 0) ? 9'h1FF : 9'($urandom_range(0, 15));
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom),
                   1'($urandom_range(0, 199) == 0),
                   2'($urandom), a, 16'($urandom));
            step();
        end
        idle_in();
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
